// File: rtl/neuron_lif_layer_if.sv
// Weight-stream channel into the LIF layer: one SYNAPSES-wide sign word per neuron,
// transferred on w_valid && w_ready.
interface neuron_lif_layer_if #(
    parameter int SYNAPSES = 32
) ();
    logic                w_valid;
    logic                w_ready;
    logic [SYNAPSES-1:0] weights;

    modport master (
        output w_valid,
        output weights,
        input  w_ready
    );

    modport slave (
        input  w_valid,
        input  weights,
        output w_ready
    );
endinterface

// File: rtl/neuron_lif_layer.sv
// Time-multiplexed layer of leaky integrate-and-fire neurons sharing one datapath.
// Each start evaluates one timestep; neuron idx consumes one streamed weight word.
module neuron_lif_layer #(
    parameter int SYNAPSES       = 32,
    parameter int NEURONS        = 8,
    parameter int MEMBRANE_BITS  = $clog2(SYNAPSES) + 2,
    parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1,
    parameter int BIAS_BITS      = MEMBRANE_BITS - 2,
    parameter int REFRACT_BITS   = 2,
    localparam int IDX_W         = $clog2(NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic                            clear_i,
    input  logic [SYNAPSES-1:0]             inputs_i,
    neuron_lif_layer_if.slave               w_if,
    input  logic [2:0]                      shift_i,
    input  logic [THRESHOLD_BITS-1:0]       threshold_i,
    input  logic signed [BIAS_BITS-1:0]     bias_i,
    input  logic                            reset_mode_i,
    input  logic [REFRACT_BITS-1:0]         refractory_period_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [NEURONS-1:0]              spikes_o,
    input  logic [IDX_W-1:0]                rd_addr_i,
    output logic signed [MEMBRANE_BITS-1:0] rd_data_o
);

    // Two guard bits hold decayed + psp + bias (and acc - threshold) without overflow.
    localparam int W     = MEMBRANE_BITS + 2;
    localparam int U_MAX = 2 ** (MEMBRANE_BITS - 1) - 1;
    localparam int U_MIN = -(2 ** (MEMBRANE_BITS - 1));

    localparam logic signed [W-1:0]             U_MAX_W  = W'(U_MAX);
    localparam logic signed [W-1:0]             U_MIN_W  = W'(U_MIN);
    localparam logic signed [MEMBRANE_BITS-1:0] U_MAX_M  = MEMBRANE_BITS'(U_MAX);
    localparam logic signed [MEMBRANE_BITS-1:0] U_MIN_M  = MEMBRANE_BITS'(U_MIN);
    localparam logic signed [W-1:0]             ONE_W    = W'(1);
    localparam logic [IDX_W-1:0]                LAST_IDX = IDX_W'(NEURONS - 1);
    localparam logic [IDX_W-1:0]                ONE_IDX  = IDX_W'(1);
    localparam logic [REFRACT_BITS-1:0]         ONE_REFR = REFRACT_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                          state_q;
    logic [IDX_W-1:0]                idx_q;
    logic                            busy_q;
    logic                            done_q;
    logic                            w_ready_q;
    logic [NEURONS-1:0]              spikes_q;
    logic [NEURONS-1:0]              spike_acc_q;
    logic [SYNAPSES-1:0]             inputs_q;
    logic signed [MEMBRANE_BITS-1:0] mem_q  [NEURONS];
    logic [REFRACT_BITS-1:0]         refr_q [NEURONS];

    logic signed [W-1:0]             u_ext;
    logic signed [W-1:0]             decayed;
    logic signed [W-1:0]             psp;
    logic signed [W-1:0]             acc;
    logic signed [W-1:0]             thr_ext;
    logic signed [W-1:0]             bias_ext;
    logic signed [W-1:0]             u_full;
    logic [REFRACT_BITS-1:0]         refr_cur;
    logic [REFRACT_BITS-1:0]         refr_d;
    logic                            spike_d;
    logic signed [MEMBRANE_BITS-1:0] u_d;
    logic [NEURONS-1:0]              spike_acc_d;

    always_comb begin
        psp = '0;
        for (int i = 0; i < SYNAPSES; i++) begin
            if (inputs_q[i]) begin
                psp = w_if.weights[i] ? psp + ONE_W : psp - ONE_W;
            end
        end
    end

    always_comb begin
        u_ext    = {{2{mem_q[idx_q][MEMBRANE_BITS-1]}}, mem_q[idx_q]};
        refr_cur = refr_q[idx_q];
        thr_ext  = {{(W - THRESHOLD_BITS){1'b0}}, threshold_i};
        bias_ext = {{(W - BIAS_BITS){bias_i[BIAS_BITS-1]}}, bias_i};
        decayed  = (shift_i == 3'd0) ? u_ext : u_ext - (u_ext >>> shift_i);
        spike_d  = 1'b0;
        refr_d   = refr_cur;
        acc      = decayed + bias_ext;
        if (refr_cur != '0) begin
            refr_d = refr_cur - ONE_REFR;
        end else begin
            acc = decayed + psp + bias_ext;
            if (acc >= thr_ext) begin
                spike_d = 1'b1;
                refr_d  = refractory_period_i;
            end
        end
        u_full = acc;
        if (spike_d) begin
            u_full = reset_mode_i ? acc - thr_ext : '0;
        end
        // The spike decision above uses the unclamped accumulator; only storage saturates.
        if (u_full > U_MAX_W) begin
            u_d = U_MAX_M;
        end else if (u_full < U_MIN_W) begin
            u_d = U_MIN_M;
        end else begin
            u_d = u_full[MEMBRANE_BITS-1:0];
        end
        spike_acc_d        = spike_acc_q;
        spike_acc_d[idx_q] = spike_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_ready_q   <= 1'b0;
            spikes_q    <= '0;
            spike_acc_q <= '0;
            inputs_q    <= '0;
            for (int n = 0; n < NEURONS; n++) begin
                mem_q[n]  <= '0;
                refr_q[n] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_i) begin
                        for (int n = 0; n < NEURONS; n++) begin
                            mem_q[n]  <= '0;
                            refr_q[n] <= '0;
                        end
                    end else if (start_i) begin
                        inputs_q    <= inputs_i;
                        spike_acc_q <= '0;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        w_ready_q   <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_if.w_valid) begin
                        mem_q[idx_q]  <= u_d;
                        refr_q[idx_q] <= refr_d;
                        spike_acc_q   <= spike_acc_d;
                        if (idx_q == LAST_IDX) begin
                            // Publish on the last write so done and spikes land together.
                            spikes_q  <= spike_acc_d;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            w_ready_q <= 1'b0;
                            idx_q     <= '0;
                            state_q   <= S_DONE;
                        end else begin
                            idx_q <= idx_q + ONE_IDX;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign w_if.w_ready = w_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign spikes_o     = spikes_q;
    assign rd_data_o    = mem_q[rd_addr_i];

endmodule
